dac_spi_frame_receiver: RTL and testbench



---
 rtl/dac_spi_frame_receiver_pkg.sv | 35 +++
 rtl/dac_spi_frame_receiver_if.sv | 43 ++++
 rtl/dac_spi_frame_receiver_sync_edge_det.sv | 33 +++
 rtl/dac_spi_frame_receiver.sv | 143 ++++++++++++++
 tb/tb_dac_spi_frame_receiver.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_frame_receiver_pkg.sv
// Shared types and constants for the DAC serial-link frame receiver.
// Frame layout: ctrl[7:0] then data[15:0], MSB first.
// The DAC select field sits at frame[18:17], which is ctrl[2:1].
package dac_rx_pkg;

    localparam int unsigned FRAME_BITS_DEF  = 24;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CTRL_W          = 8;
    localparam int unsigned CHAN_W          = 2;
    localparam int unsigned NUM_CHAN        = 4;
    localparam int unsigned CTRL_LSB        = 16;
    localparam int unsigned CHAN_LSB        = 17;
    localparam int unsigned CHAN_MSB        = 18;
    localparam int unsigned COUNT_W         = 16;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } rx_state_e;

    // Decoded view of one default-size frame.
    typedef struct packed {
        logic [CTRL_W-1:0]     ctrl;
        logic [DATA_W_DEF-1:0] data;
    } rx_frame_t;

    // Pull the DAC select field out of a control byte.
    function automatic logic [CHAN_W-1:0] chan_of(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CHAN_MSB-CTRL_LSB -: CHAN_W];
    endfunction

endpackage

// File: rtl/dac_spi_frame_receiver_if.sv
// Serial link pins plus decoded-frame outputs of the DAC frame receiver.
// master: drives the link and observes the results (bench / loopback source).
// slave : the receiver itself.
// Optional macro DAC_RX_CHAN_REGS_EN adds chan_regs[63:0] (4 x 16-bit holding regs).
interface dac_spi_frame_receiver_if #(
    parameter int unsigned DATA_W = 16
);
    logic              spi_sync;
    logic              spi_sclk;
    logic              spi_din;
    logic [DATA_W-1:0] rx_word;
    logic [7:0]        rx_ctrl;
    logic [1:0]        rx_chan;
    logic              rx_valid;
    logic              rx_frame_err;
    logic [15:0]       rx_frame_count;
    logic              busy;
`ifdef DAC_RX_CHAN_REGS_EN
    logic [4*DATA_W-1:0] chan_regs;

    modport master (
        output spi_sync, spi_sclk, spi_din,
        input  rx_word, rx_ctrl, rx_chan, rx_valid, rx_frame_err,
               rx_frame_count, busy, chan_regs
    );
    modport slave (
        input  spi_sync, spi_sclk, spi_din,
        output rx_word, rx_ctrl, rx_chan, rx_valid, rx_frame_err,
               rx_frame_count, busy, chan_regs
    );
`else
    modport master (
        output spi_sync, spi_sclk, spi_din,
        input  rx_word, rx_ctrl, rx_chan, rx_valid, rx_frame_err,
               rx_frame_count, busy
    );
    modport slave (
        input  spi_sync, spi_sclk, spi_din,
        output rx_word, rx_ctrl, rx_chan, rx_valid, rx_frame_err,
               rx_frame_count, busy
    );
`endif
endinterface

// File: rtl/dac_spi_frame_receiver_sync_edge_det.sv
// Synchronizer chain plus one "prev" flop for a single asynchronous input.
// Ports: dataclk, reset (sync, active-high), din (async pin),
//        level (synchronized value), rise / fall (one-cycle edge strobes).
module sync_edge_det #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic dataclk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    // Metastability chain, then a delayed copy for edge detection.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/dac_spi_frame_receiver.sv
// Receive-side monitor for the 3-wire DAC link (SYNC/SCLK/DIN). Oversamples
// the link on dataclk, deserializes FRAME_BITS-bit frames sampled on SCLK
// falling edges, reports good frames and flags frames cut short by SYNC.
// Ports: dataclk, reset (sync, active-high), bus (slave modport: spi_* in;
//        rx_word/rx_ctrl/rx_chan/rx_valid/rx_frame_err/rx_frame_count/busy out).
// Optional macro DAC_RX_CHAN_REGS_EN: per-channel holding registers on bus.chan_regs.
module dac_spi_frame_receiver
    import dac_rx_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic                    dataclk,
    input logic                    reset,
    dac_spi_frame_receiver_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 1);
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic sync_lvl, sync_rise, sync_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic din_lvl, din_rise, din_fall;
    logic unused_edges;

    rx_state_e             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shift_next;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  settle_done;
    logic [CTRL_W-1:0]     new_ctrl;
    logic [CHAN_W-1:0]     new_chan;
    logic [DATA_W-1:0]     new_word;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
        .dataclk(dataclk), .reset(reset), .din(bus.spi_sync),
        .level(sync_lvl), .rise(sync_rise), .fall(sync_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (
        .dataclk(dataclk), .reset(reset), .din(bus.spi_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din (
        .dataclk(dataclk), .reset(reset), .din(bus.spi_din),
        .level(din_lvl), .rise(din_rise), .fall(din_fall)
    );

    assign unused_edges = ^{sclk_lvl, sclk_rise, din_rise, din_fall};

    // Shift value including the bit being captured this cycle.
    assign shift_next = {shreg[FRAME_BITS-2:0], din_lvl};
    assign new_ctrl   = shift_next[CTRL_LSB +: CTRL_W];
    assign new_chan   = chan_of(new_ctrl);
    assign new_word   = shift_next[DATA_W-1:0];

    // The synchronizer holds its reset value for SYNC_STAGES cycles; WAIT_HIGH
    // must not trust that value, or a frame in flight across reset would be
    // picked up mid-way and reported as an error.
    assign settle_done = (settle_cnt == SETTLE_W'(SYNC_STAGES));

    // Frame FSM with registered outputs.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            state              <= WAIT_HIGH;
            bit_cnt            <= '0;
            shreg              <= '0;
            settle_cnt         <= '0;
            bus.rx_word        <= '0;
            bus.rx_ctrl        <= '0;
            bus.rx_chan        <= '0;
            bus.rx_valid       <= 1'b0;
            bus.rx_frame_err   <= 1'b0;
            bus.rx_frame_count <= '0;
            bus.busy           <= 1'b0;
`ifdef DAC_RX_CHAN_REGS_EN
            bus.chan_regs      <= '0;
`endif
        end else begin
            bus.rx_valid     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            if (!settle_done) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end

            case (state)
                WAIT_HIGH: begin
                    if (settle_done && sync_lvl) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (sync_fall) begin
                        state    <= SHIFT;
                        bus.busy <= 1'b1;
                        if (sclk_fall) begin
                            shreg   <= shift_next;
                            bit_cnt <= CNT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    // SYNC rise wins over a coincident SCLK fall.
                    if (sync_rise) begin
                        bus.rx_frame_err <= 1'b1;
                        bus.busy         <= 1'b0;
                        state            <= IDLE;
                    end else if (sclk_fall && !sync_lvl) begin
                        shreg <= shift_next;
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            bus.rx_ctrl        <= new_ctrl;
                            bus.rx_chan        <= new_chan;
                            bus.rx_word        <= new_word;
                            bus.rx_valid       <= 1'b1;
                            bus.rx_frame_count <= bus.rx_frame_count + 16'd1;
                            bus.busy           <= 1'b0;
                            state              <= DONE;
`ifdef DAC_RX_CHAN_REGS_EN
                            for (int i = 0; i < NUM_CHAN; i++) begin
                                if (new_chan == CHAN_W'(i)) begin
                                    bus.chan_regs[i*DATA_W +: DATA_W] <= new_word;
                                end
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Surplus SCLK edges are ignored until the frame closes.
                    if (sync_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
// Directed bench for dac_spi_frame_receiver: drives the link pins at the
// dataclk negedge, samples outputs on the negedge, checks hand-computed values.
module tb_dac_spi_frame_receiver;
    import dac_rx_pkg::*;

    logic dataclk = 1'b0;
    logic reset;

    always #5 dataclk = ~dataclk;

    dac_spi_frame_receiver_if #(.DATA_W(16)) bus ();

    dac_spi_frame_receiver dut (
        .dataclk(dataclk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int valid_cyc = 0;
    int fall_cyc  = 0;
    int v0, e0;
    logic [15:0] cap_word[$];
    logic [1:0]  cap_chan[$];

    always @(posedge dataclk) cyc <= cyc + 1;

    // Pulse monitor.
    always @(negedge dataclk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            cap_word.push_back(bus.rx_word);
            cap_chan.push_back(bus.rx_chan);
        end
        if (bus.rx_frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge dataclk);
    endtask

    // One bit: data set with SCLK high for 2 cycles, then SCLK low for 2.
    task automatic clock_bit(input logic b);
        bus.spi_din  = b;
        bus.spi_sclk = 1'b1;
        wait_cyc(2);
        bus.spi_sclk = 1'b0;
        fall_cyc     = cyc;
        wait_cyc(2);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) clock_bit(v[i]);
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, input int hi);
        bus.spi_sync = 1'b0;
        wait_cyc(2);
        send_bits(v, n);
        bus.spi_sync = 1'b1;
        bus.spi_sclk = 1'b1;
        wait_cyc(hi);
    endtask

    initial begin
        reset        = 1'b1;
        bus.spi_sync = 1'b1;
        bus.spi_sclk = 1'b1;
        bus.spi_din  = 1'b0;
        wait_cyc(3);
        check("reset_valid", bus.rx_valid, 0);
        check("reset_err",   bus.rx_frame_err, 0);
        check("reset_word",  bus.rx_word, 0);
        check("reset_ctrl",  bus.rx_ctrl, 0);
        check("reset_chan",  bus.rx_chan, 0);
        check("reset_count", bus.rx_frame_count, 0);
        check("reset_busy",  bus.busy, 0);
        reset = 1'b0;
        wait_cyc(6);

        // Single frame 0x14_8000; valid 3 edges after the last SCLK fall.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(32'h0014_8000, 24, 4);
        wait_cyc(4);
        check("t1_valid_pulses", valid_cnt - v0, 1);
        check("t1_no_err",  err_cnt - e0, 0);
        check("t1_latency", valid_cyc - fall_cyc, 3);
        check("t1_ctrl",    bus.rx_ctrl, 8'h14);
        check("t1_chan",    bus.rx_chan, 2);
        check("t1_word",    bus.rx_word, 16'h8000);
        check("t1_count",   bus.rx_frame_count, 1);
        check("t1_busy",    bus.busy, 0);

        // Zero-bit frame: SYNC low then high with no SCLK.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(32'h0, 0, 4);
        wait_cyc(2);
        check("t0bit_err",   err_cnt - e0, 1);
        check("t0bit_valid", valid_cnt - v0, 0);

        // Back-to-back frames, SYNC high for 2 cycles between.
        v0 = valid_cnt; e0 = err_cnt;
        cap_word.delete(); cap_chan.delete();
        send_frame(32'h0010_ABCD, 24, 2);
        send_frame(32'h0012_0001, 24, 4);
        wait_cyc(4);
        check("t2_valid_pulses", valid_cnt - v0, 2);
        check("t2_no_err", err_cnt - e0, 0);
        check("t2_chan_a", cap_chan[0], 0);
        check("t2_word_a", cap_word[0], 16'hABCD);
        check("t2_chan_b", cap_chan[1], 1);
        check("t2_word_b", cap_word[1], 16'h0001);
        check("t2_count",  bus.rx_frame_count, 3);

        // Truncated after 13 bits of 0x14_FFFF.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(32'h0014_FFFF >> 11, 13, 4);
        wait_cyc(4);
        check("t3_err",      err_cnt - e0, 1);
        check("t3_no_valid", valid_cnt - v0, 0);
        check("t3_word_hold", bus.rx_word, 16'h0001);
        check("t3_ctrl_hold", bus.rx_ctrl, 8'h12);
        check("t3_chan_hold", bus.rx_chan, 1);
        check("t3_count_hold", bus.rx_frame_count, 3);
        send_frame(32'h0011_C3C3, 24, 4);
        wait_cyc(4);
        check("t3_next_valid", valid_cnt - v0, 1);
        check("t3_next_word", bus.rx_word, 16'hC3C3);
        check("t3_next_chan", bus.rx_chan, 0);
        check("t3_next_count", bus.rx_frame_count, 4);

        // 30 SCLK falls in one window; first 24 bits are 0x16_1234.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame({2'b00, 24'h16_1234, 6'b101011}, 30, 4);
        wait_cyc(4);
        check("t4_valid_pulses", valid_cnt - v0, 1);
        check("t4_no_err", err_cnt - e0, 0);
        check("t4_chan",  bus.rx_chan, 3);
        check("t4_word",  bus.rx_word, 16'h1234);
        check("t4_ctrl",  bus.rx_ctrl, 8'h16);
        check("t4_count", bus.rx_frame_count, 5);

        // Reset mid-frame with SYNC held low; the remainder must be discarded.
        v0 = valid_cnt; e0 = err_cnt;
        bus.spi_sync = 1'b0;
        wait_cyc(2);
        send_bits(32'h0015_5555 >> 14, 10);
        check("t5_busy_mid", bus.busy, 1);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        check("t5_count_rst", bus.rx_frame_count, 0);
        check("t5_busy_rst",  bus.busy, 0);
        check("t5_word_rst",  bus.rx_word, 0);
        send_bits(32'h0015_5555 & 32'h3FFF, 14);
        bus.spi_sync = 1'b1;
        bus.spi_sclk = 1'b1;
        wait_cyc(6);
        check("t5_no_valid", valid_cnt - v0, 0);
        check("t5_no_err",   err_cnt - e0, 0);
        send_frame(32'h0010_5A5A, 24, 4);
        wait_cyc(4);
        check("t5_valid", valid_cnt - v0, 1);
        check("t5_word",  bus.rx_word, 16'h5A5A);
        check("t5_chan",  bus.rx_chan, 0);
        check("t5_count", bus.rx_frame_count, 1);

`ifdef DAC_RX_CHAN_REGS_EN
        // Per-channel holding registers.
        send_frame(32'h0010_1111, 24, 4);
        send_frame(32'h0012_2222, 24, 4);
        send_frame(32'h0014_3333, 24, 4);
        send_frame(32'h0016_4444, 24, 4);
        wait_cyc(4);
        check("t6_regs_all", bus.chan_regs, 64'h4444_3333_2222_1111);
        send_frame(32'h0012_BEEF, 24, 4);
        wait_cyc(4);
        check("t6_regs_ch1", bus.chan_regs, 64'h4444_3333_BEEF_1111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
